seg_scan_monitor: RTL and testbench
===================================

SEG_SCAN_MONITOR -- requirements
Module: seg_scan_monitor

Interface
REQ-001 The block SHALL be driven by one clock; reset is asynchronous and active-high.
REQ-002 Parameter SCAN_DIV, default 17, SHALL set the divider width; one digit advance occurs every 2^SCAN_DIV clk cycles.
REQ-003 Parameter RC_HOLD, default 1000000, SHALL set the rc_led stretch length in clk cycles (minimum 1).
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port cnt_in  input  32  count value from the upstream up/down counter.
REQ-007 Port rc_in  input  1  upstream ripple-carry/borrow flag (registered, may stay high several cycles).
REQ-008 Port freeze  input  1  when high, the displayed snapshot is held.
REQ-009 Port clear_wraps  input  1  synchronous clear of wrap_count.
REQ-010 Port AN  output  8  digit anodes, active-low, one-hot.
REQ-011 Port SEG  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-012 Port rc_led  output  1  stretched wrap indicator.
REQ-013 Port wrap_count  output  8  saturating count of wrap events.

Function
REQ-014 A SCAN_DIV-bit free-running divider SHALL increment every cycle; tick = divider all-ones.
REQ-015 A 3-bit digit index SHALL increment on tick, wrapping 7->0.
REQ-016 AN SHALL be all-ones except bit [index] = 0; digit 0 is rightmost and shows snapshot[3:0], digit i shows snapshot[4i+3:4i].
REQ-017 The 32-bit snapshot SHALL load cnt_in on a tick with index==7 and freeze==0; otherwise it holds, so a frame never mixes two values.
REQ-018 SEG[6:0] SHALL be the hex decode of the selected nibble: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E (dp bit shown as 1).
REQ-019 Leading-zero blanking: digit i>0 SHALL output SEG=8'hFF if snapshot[31:4i]==0; digit 0 is never blanked.
REQ-020 SEG[7] (dp) SHALL be 0 only on digit 0 while rc_led==1 and while digit 0 is active.
REQ-021 AN and SEG SHALL be registered, updating the cycle after index changes (1-cycle latency).
REQ-022 A wrap event SHALL be rc_in==1 with its registered previous value ==0 (rising edge); a held-high rc_in is one event.
REQ-023 On an event, rc_led SHALL go 1 the next cycle and a hold counter SHALL load RC_HOLD-1; it decrements each cycle and rc_led clears the cycle after it reaches 0 (rc_led high exactly RC_HOLD cycles).
REQ-024 An event during an active hold SHALL restart the hold counter (retrigger).
REQ-025 Each event SHALL increment wrap_count, saturating at 255.
REQ-026 clear_wraps SHALL set wrap_count to 0 the next cycle; clear_wraps and an event in the same cycle SHALL yield 0.
REQ-027 freeze SHALL not affect scanning, rc_led or wrap_count.

Reset
REQ-028 While rst==1, immediately and asynchronously: divider=0, index=0, snapshot=0, rc edge register=0, hold counter=0, rc_led=0, wrap_count=0, AN=8'hFE, SEG=8'hC0.
REQ-029 After rst falls, the first snapshot load SHALL occur on the first tick with index==7; reset mid-frame SHALL abandon the frame.

Verification (SCAN_DIV=2, RC_HOLD=5)
REQ-030 Reset, cnt_in=32'h0000_00A5, run one frame -> next frame AN cycles FE,FD,...,7F; digit0 SEG=92, digit1 SEG=88, digits 2-7 SEG=FF.
REQ-031 cnt_in=32'hFFFF_FFFF then freeze=1 and cnt_in=0 for two frames -> all digits show 8E, snapshot unchanged.
REQ-032 rc_in high 3 cycles -> one event: wrap_count=1, rc_led high exactly 5 cycles, dp low only while digit 0 active.
REQ-033 Second rc_in edge 3 cycles after first -> rc_led stays high 5 cycles past second event, wrap_count=2.
REQ-034 300 events -> wrap_count=255; clear_wraps coincident with an event -> wrap_count=0.
REQ-035 Assert rst mid-frame with rc_led=1 -> outputs at REQ-028 values in the same cycle, no clock needed.

Source files
------------

// File: rtl/seg_scan_monitor.sv
// Eight-digit multiplexed hex display of a 32-bit counter snapshot, with a
// stretched wrap indicator (rc_led on digit 0's dp) and a saturating wrap tally.
module seg_scan_monitor #(
  parameter int SCAN_DIV = 17,
  parameter int RC_HOLD  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cnt_in,
  input  logic        rc_in,
  input  logic        freeze,
  input  logic        clear_wraps,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        rc_led,
  output logic [7:0]  wrap_count
);

  localparam int HOLD_W = (RC_HOLD > 1) ? $clog2(RC_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RC_HOLD - 1);

  logic [SCAN_DIV-1:0] div_q, div_d;
  logic [2:0]          idx_q, idx_d;
  logic [31:0]         snap_q, snap_d;
  logic                rc_prev_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                led_q, led_d;
  logic [7:0]          wraps_q, wraps_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic        tick;
  logic        wrap_evt;
  logic [31:0] upper;
  logic [3:0]  nibble;
  logic [6:0]  hex;
  logic        blank;

  assign tick     = &div_q;
  assign wrap_evt = rc_in & ~rc_prev_q;

  // Snapshot only reloads at the end of a full frame so a frame never mixes values.
  always_comb begin
    div_d  = div_q + SCAN_DIV'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    if (tick) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7 && !freeze) begin
        snap_d = cnt_in;
      end
    end
  end

  always_comb begin
    upper  = snap_q >> {idx_q, 2'b00};
    nibble = upper[3:0];
    blank  = (idx_q != 3'd0) && (upper == 32'd0);
    hex    = 7'h7F;
    case (nibble)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
    an_d  = ~(8'h01 << idx_q);
    seg_d = blank ? 8'hFF : {~((idx_q == 3'd0) && led_q), hex};
  end

  // Hold counter holds the remaining extra cycles; a fresh edge always restarts it.
  always_comb begin
    hold_d  = hold_q;
    led_d   = led_q;
    wraps_d = wraps_q;
    if (wrap_evt) begin
      led_d  = 1'b1;
      hold_d = HOLD_LOAD;
    end else if (led_q) begin
      if (hold_q == '0) begin
        led_d = 1'b0;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end
    if (clear_wraps) begin
      wraps_d = 8'd0;
    end else if (wrap_evt && wraps_q != 8'hFF) begin
      wraps_d = wraps_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= 3'd0;
      snap_q    <= 32'd0;
      rc_prev_q <= 1'b0;
      hold_q    <= '0;
      led_q     <= 1'b0;
      wraps_q   <= 8'd0;
      an_q      <= 8'hFE;
      seg_q     <= 8'hC0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      rc_prev_q <= rc_in;
      hold_q    <= hold_d;
      led_q     <= led_d;
      wraps_q   <= wraps_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign rc_led     = led_q;
  assign wrap_count = wraps_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Randomised and directed bench for seg_scan_monitor, checked every cycle
// against a behavioural display/wrap model held in the bench.
module tb_seg_scan_monitor;

  localparam int SCAN_DIV = 2;
  localparam int RC_HOLD  = 5;
  localparam int DIVN     = 1 << SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt_in;
  logic        rc_in;
  logic        freeze;
  logic        clear_wraps;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        rc_led;
  logic [7:0]  wrap_count;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_monitor #(.SCAN_DIV(SCAN_DIV), .RC_HOLD(RC_HOLD)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .rc_in(rc_in), .freeze(freeze),
    .clear_wraps(clear_wraps), .AN(AN), .SEG(SEG), .rc_led(rc_led),
    .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: cycles since reset, digit position, frame value, led cycles left.
  int          mCyc = 0;
  int          mIdx = 0;
  logic [31:0] mSnap = 32'd0;
  bit          mRcPrev = 1'b0;
  int          mLedLeft = 0;
  int          mWraps = 0;
  logic [7:0]  expAN = 8'hFE;
  logic [7:0]  expSEG = 8'hC0;
  logic        expLed = 1'b0;
  logic [7:0]  expWraps = 8'd0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  task automatic checkOutput();
    cmp("AN", {24'd0, AN}, {24'd0, expAN});
    cmp("SEG", {24'd0, SEG}, {24'd0, expSEG});
    cmp("rc_led", {31'd0, rc_led}, {31'd0, expLed});
    cmp("wrap_count", {24'd0, wrap_count}, {24'd0, expWraps});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCyc = 0; mIdx = 0; mSnap = 32'd0; mRcPrev = 1'b0; mLedLeft = 0; mWraps = 0;
      expAN = 8'hFE; expSEG = 8'hC0; expLed = 1'b0; expWraps = 8'd0;
    end else begin
      logic [31:0] up;
      bit evt;
      up     = mSnap >> (4 * mIdx);
      expAN  = 8'hFF ^ (8'h01 << mIdx);
      if (mIdx > 0 && up == 32'd0) expSEG = 8'hFF;
      else expSEG = HEX[up[3:0]] & ((mIdx == 0 && mLedLeft > 0) ? 8'h7F : 8'hFF);
      evt = rc_in && !mRcPrev;
      if (evt) mLedLeft = RC_HOLD;
      else if (mLedLeft > 0) mLedLeft--;
      expLed = (mLedLeft > 0);
      if (clear_wraps) mWraps = 0;
      else if (evt && mWraps < 255) mWraps++;
      expWraps = 8'(mWraps);
      if (mCyc % DIVN == DIVN - 1) begin
        if (mIdx == 7 && !freeze) mSnap = cnt_in;
        mIdx = (mIdx + 1) % 8;
      end
      mCyc++;
      mRcPrev = rc_in;
    end
    #1;
    checkOutput();
  end

  task automatic applyStimulus(input logic [31:0] c, input logic r, input logic f, input logic cw);
    @(negedge clk);
    cnt_in = c; rc_in = r; freeze = f; clear_wraps = cw;
  endtask

  task automatic findDigit(input int d);
    logic [7:0] want;
    int n;
    want = 8'hFF ^ (8'h01 << d);
    n = 0;
    while (expAN != want && n < 40) begin
      @(negedge clk);
      n++;
    end
    cmp("AN digit select", {24'd0, AN}, {24'd0, want});
  endtask

  int hi;

  initial begin
    rst = 1'b1; cnt_in = 32'd0; rc_in = 1'b0; freeze = 1'b0; clear_wraps = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset AN", {24'd0, AN}, 32'hFE);
    cmp("reset SEG", {24'd0, SEG}, 32'hC0);
    cmp("reset wrap_count", {24'd0, wrap_count}, 32'h0);
    rst = 1'b0;

    // 0xA5: digit0 '5', digit1 'A', the rest blanked
    for (int k = 0; k < 80; k++) applyStimulus(32'h0000_00A5, 1'b0, 1'b0, 1'b0);
    findDigit(0);
    cmp("A5 digit0 SEG", {24'd0, SEG}, 32'h92);
    cmp("model digit0 SEG", {24'd0, expSEG}, 32'h92);
    for (int d = 1; d < 8; d++) begin
      findDigit(d);
      cmp("A5 upper SEG", {24'd0, SEG}, (d == 1) ? 32'h88 : 32'hFF);
    end

    for (int k = 0; k < 70; k++) applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 70; k++) applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 8; d++) begin
      findDigit(d);
      cmp("frozen F SEG", {24'd0, SEG}, 32'h8E);
    end

    hi = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(32'h0, k < 3, 1'b0, 1'b0);
      if (rc_led) hi++;
    end
    cmp("single event led cycles", hi, 5);
    cmp("single event wraps", {24'd0, wrap_count}, 32'd1);

    hi = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(32'h0, (k == 0 || k == 3), 1'b0, 1'b0);
      if (rc_led) hi++;
    end
    cmp("retrigger led cycles", hi, 8);
    cmp("retrigger wraps", {24'd0, wrap_count}, 32'd3);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(32'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    end
    cmp("saturated wraps", {24'd0, wrap_count}, 32'd255);
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    cmp("clear with event", {24'd0, wrap_count}, 32'd0);

    for (int k = 0; k < 3000; k++)
      applyStimulus($urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0);

    applyStimulus(32'h1234_5678, 1'b0, 1'b0, 1'b0);
    findDigit(3);
    applyStimulus(32'h1234_5678, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 1'b0, 1'b0, 1'b0);
    cmp("led before reset", {31'd0, rc_led}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("async reset AN", {24'd0, AN}, 32'hFE);
    cmp("async reset SEG", {24'd0, SEG}, 32'hC0);
    cmp("async reset rc_led", {31'd0, rc_led}, 32'd0);
    cmp("async reset wraps", {24'd0, wrap_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 500; k++)
      applyStimulus($urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 63) == 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
